// File: rtl/vstore_op_sender.sv
// Store-operand sender: accepts one vector-store instruction at a time, buffers
// its VRF beats in a small FIFO and streams them to the LSU, then pulses done_o.
module vstore_op_sender #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned Depth     = 4,
  parameter int unsigned MaxBeats  = 8,
  parameter int unsigned CntWidth  = $clog2(MaxBeats + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 insn_valid_i,
  output logic                 insn_ready_o,
  input  logic [IdWidth-1:0]   insn_id_i,
  input  logic [CntWidth-1:0]  beat_cnt_i,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [DataWidth-1:0] op_data_i,
  output logic                 store_op_valid_o,
  output logic [DataWidth-1:0] store_op_o,
  input  logic                 store_op_gnt_i,
  output logic                 done_o,
  output logic [IdWidth-1:0]   done_insn_id_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  mem_q [Depth];
  logic [DataWidth-1:0]  mem_d [Depth];
  logic [PtrWidth-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrWidth:0]     count_q, count_d;
  logic [CntWidth-1:0]   in_rem_q, in_rem_d, out_rem_q, out_rem_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic                  fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PtrWidth + 1)'(Depth));

  // Full blocks acceptance outright, even when the head is popped this cycle.
  assign insn_ready_o     = (state_q == IDLE) && !flush_i;
  assign op_ready_o       = (state_q == ACTIVE) && (in_rem_q != '0) && !fifo_full && !flush_i;
  assign store_op_valid_o = !fifo_empty;
  assign store_op_o       = fifo_empty ? '0 : mem_q[rptr_q];
  assign done_o           = (state_q == DONE);
  assign done_insn_id_o   = done_o ? id_q : '0;

  assign push = op_valid_i && op_ready_o;
  assign pop  = store_op_valid_o && store_op_gnt_i;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    in_rem_d  = in_rem_q;
    out_rem_d = out_rem_q;
    id_d      = id_q;

    if (push) begin
      mem_d[wptr_q] = op_data_i;
      wptr_d        = wptr_q + PtrWidth'(1);
      in_rem_d      = in_rem_q - CntWidth'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrWidth'(1);
      if (out_rem_q != '0) out_rem_d = out_rem_q - CntWidth'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrWidth + 1)'(1);
      2'b01:   count_d = count_q - (PtrWidth + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (insn_valid_i && insn_ready_o) begin
          id_d = insn_id_i;
          if (beat_cnt_i != '0) begin
            in_rem_d  = beat_cnt_i;
            out_rem_d = beat_cnt_i;
            state_d   = ACTIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACTIVE:  if (pop && (out_rem_q == CntWidth'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d   = IDLE;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      in_rem_d  = '0;
      out_rem_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      in_rem_q  <= '0;
      out_rem_q <= '0;
      id_q      <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      in_rem_q  <= in_rem_d;
      out_rem_q <= out_rem_d;
      id_q      <= id_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_vstore_op_sender.sv
// Directed bench for vstore_op_sender: transfer, backpressure, zero-length,
// flush, excess/spurious handshakes, back-to-back instructions, mid-op reset.
module tb_vstore_op_sender;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        insn_valid_i;
  logic        insn_ready_o;
  logic [2:0]  insn_id_i;
  logic [3:0]  beat_cnt_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [63:0] op_data_i;
  logic        store_op_valid_o;
  logic [63:0] store_op_o;
  logic        store_op_gnt_i;
  logic        done_o;
  logic [2:0]  done_insn_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  vstore_op_sender #(
    .DataWidth(64),
    .IdWidth  (3),
    .Depth    (4),
    .MaxBeats (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .insn_valid_i    (insn_valid_i),
    .insn_ready_o    (insn_ready_o),
    .insn_id_i       (insn_id_i),
    .beat_cnt_i      (beat_cnt_i),
    .op_valid_i      (op_valid_i),
    .op_ready_o      (op_ready_o),
    .op_data_i       (op_data_i),
    .store_op_valid_o(store_op_valid_o),
    .store_op_o      (store_op_o),
    .store_op_gnt_i  (store_op_gnt_i),
    .done_o          (done_o),
    .done_insn_id_o  (done_insn_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic start_insn(input logic [2:0] id, input int cnt, input bit hold);
    insn_valid_i = 1'b1;
    insn_id_i    = id;
    beat_cnt_i   = 4'(cnt);
    #1;
    check_eq("insn_ready_idle", insn_ready_o, 1);
    @(posedge clk_i); #1;
    if (!hold) insn_valid_i = 1'b0;
  endtask

  // Streams n beats base, base+1, ... and checks order, latency and completion.
  task automatic run_store(input logic [2:0] id, input int n, input logic [63:0] base,
                           input int gnt_low, input int src_delay);
    int src, outc, first_acc, last_gnt, dones;
    bit seen_valid;
    src = 0; outc = 0; first_acc = -1; last_gnt = -10; dones = 0; seen_valid = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      op_valid_i     = (cyc >= src_delay);
      op_data_i      = base + 64'(src);
      store_op_gnt_i = (cyc >= gnt_low);
      #1;
      check_eq("insn_ready_busy", insn_ready_o, 0);
      if (src >= n) check_eq("excess_op_ready", op_ready_o, 0);
      if (gnt_low > 0 && cyc == gnt_low) begin
        check_eq("bp_accepts", src, 4);
        check_eq("full_no_popthru", op_ready_o, 0);
      end
      if (store_op_valid_o) begin
        if (!seen_valid) begin
          seen_valid = 1;
          check_eq("first_valid_lat", cyc, first_acc + 1);
        end
        check_eq("head_data", store_op_o, base + 64'(outc));
        if (store_op_gnt_i) begin
          outc++;
          last_gnt = cyc;
        end
      end
      if (done_o) begin
        dones++;
        check_eq("done_id", done_insn_id_o, id);
        check_eq("done_lat", cyc, last_gnt + 1);
        check_eq("done_all_out", outc, n);
      end
      if (op_valid_i && op_ready_o) begin
        if (first_acc < 0) first_acc = cyc;
        src++;
      end
      @(posedge clk_i); #1;
      if (dones > 0) break;
    end
    check_eq("done_count", dones, 1);
    op_valid_i     = 1'b0;
    store_op_gnt_i = 1'b0;
  endtask

  initial begin
    int src, grants;
    rst_ni = 1'b0; flush_i = 1'b0; insn_valid_i = 1'b0; insn_id_i = '0; beat_cnt_i = '0;
    op_valid_i = 1'b0; op_data_i = '0; store_op_gnt_i = 1'b0;
    #3;
    check_eq("rst_insn_ready", insn_ready_o, 1);
    check_eq("rst_op_ready", op_ready_o, 0);
    check_eq("rst_valid", store_op_valid_o, 0);
    check_eq("rst_data", store_op_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_done_id", done_insn_id_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic transfer, then backpressure, then spurious grants on an empty FIFO.
    start_insn(3'd5, 8, 0);
    run_store(3'd5, 8, 64'h10, 0, 0);
    start_insn(3'd7, 8, 0);
    run_store(3'd7, 8, 64'h10, 6, 0);
    store_op_gnt_i = 1'b1;
    #1;
    check_eq("spurious_idle_valid", store_op_valid_o, 0);
    @(posedge clk_i); #1;
    store_op_gnt_i = 1'b0;
    start_insn(3'd0, 4, 0);
    run_store(3'd0, 4, 64'h40, 0, 2);

    // Zero-length store.
    start_insn(3'd2, 0, 0);
    check_eq("zl_done", done_o, 1);
    check_eq("zl_done_id", done_insn_id_o, 2);
    check_eq("zl_valid", store_op_valid_o, 0);
    check_eq("zl_insn_ready", insn_ready_o, 0);
    @(posedge clk_i); #1;
    check_eq("zl_ready_back", insn_ready_o, 1);
    check_eq("zl_done_clear", done_o, 0);
    check_eq("zl_valid_after", store_op_valid_o, 0);

    // Flush after three grants.
    start_insn(3'd3, 6, 0);
    src = 0; grants = 0;
    for (int c = 0; c < 30 && grants < 3; c++) begin
      op_valid_i = 1'b1; op_data_i = 64'h30 + 64'(src); store_op_gnt_i = 1'b1;
      #1;
      if (store_op_valid_o) begin
        check_eq("flush_head", store_op_o, 64'h30 + 64'(grants));
        grants++;
      end
      check_eq("flush_no_done", done_o, 0);
      if (op_ready_o) src++;
      @(posedge clk_i); #1;
    end
    check_eq("flush_grants", grants, 3);
    flush_i = 1'b1;
    #1;
    check_eq("flush_op_ready", op_ready_o, 0);
    check_eq("flush_insn_ready", insn_ready_o, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; op_valid_i = 1'b0; store_op_gnt_i = 1'b0;
    check_eq("flush_empty", store_op_valid_o, 0);
    check_eq("flush_data0", store_op_o, 0);
    for (int c = 0; c < 3; c++) begin
      check_eq("flush_no_done_after", done_o, 0);
      @(posedge clk_i); #1;
    end
    start_insn(3'd4, 2, 0);
    run_store(3'd4, 2, 64'h50, 0, 0);

    // Back-to-back instructions with insn_valid_i held high.
    start_insn(3'd1, 3, 1);
    insn_id_i = 3'd6; beat_cnt_i = 4'd2;
    run_store(3'd1, 3, 64'h60, 0, 0);
    start_insn(3'd6, 2, 0);
    run_store(3'd6, 2, 64'h70, 0, 0);

    // Asynchronous reset with buffered data.
    start_insn(3'd2, 4, 0);
    op_valid_i = 1'b1; op_data_i = 64'h80;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check_eq("mid_valid_before", store_op_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_valid", store_op_valid_o, 0);
    check_eq("mid_rst_data", store_op_o, 0);
    check_eq("mid_rst_insn_ready", insn_ready_o, 1);
    check_eq("mid_rst_op_ready", op_ready_o, 0);
    op_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_eq("post_rst_done", done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vstore_op_sender.md
Name: vstore_op_sender

Overview:
- Transmitting end of the store-operand channel from rvv_core to the scalar core's LSU.
- Accepts one vector-store instruction at a time, with its beat count, from the rvv_core dispatch logic.
- Buffers the VRF read beats for that store in a small FIFO and presents them on the store_op valid/gnt interface.
- Reports completion with done_o and the instruction ID after the last beat has been granted.

Parameters:
- DataWidth, 64, width of one store beat (vrf_data_t).
- IdWidth, 3, width of insn_id_t.
- Depth, 4, FIFO entries; must be a power of two and at least 2.
- MaxBeats, 8, maximum beats per store instruction.
- CntWidth, $clog2(MaxBeats+1), width of the beat counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  abort the current store and empty the buffer.
- insn_valid_i  in  1  store instruction offered.
- insn_ready_o  out  1  sender can accept an instruction.
- insn_id_i  in  IdWidth  ID of the offered instruction.
- beat_cnt_i  in  CntWidth  number of beats for the offered store (0..MaxBeats).
- op_valid_i  in  1  VRF beat offered.
- op_ready_o  out  1  beat accepted this cycle when op_valid_i is also high.
- op_data_i  in  DataWidth  beat data.
- store_op_valid_o  out  1  FIFO head valid toward the LSU.
- store_op_o  out  DataWidth  FIFO head data.
- store_op_gnt_i  in  1  LSU consumes the head.
- done_o  out  1  one-cycle completion pulse.
- done_insn_id_o  out  IdWidth  ID of the completed store; valid while done_o is high.

Behaviour:
- Reset state:
  - State IDLE; FIFO empty; in_rem = out_rem = 0; id register = 0.
  - All outputs 0 except insn_ready_o = 1.
  - store_op_o = 0 while the FIFO is empty.
- State machine: IDLE, ACTIVE, DONE.
  - IDLE: insn_ready_o = !flush_i.
    - On accept with beat_cnt_i > 0: latch insn_id_i; in_rem = out_rem = beat_cnt_i; go to ACTIVE.
    - On accept with beat_cnt_i == 0: latch the ID and go straight to DONE.
  - ACTIVE: insn_ready_o = 0.
    - op_ready_o = (in_rem != 0) && !fifo_full && !flush_i.
    - Each op handshake pushes one beat and decrements in_rem.
    - Each store handshake (store_op_valid_o && store_op_gnt_i) pops the head and decrements out_rem.
    - When the pop that takes out_rem from 1 to 0 occurs, go to DONE.
  - DONE: lasts exactly 1 cycle.
    - done_o = 1 and done_insn_id_o = latched ID.
    - insn_ready_o = 0; next state is IDLE.
    - Completion latency: done_o is high in the cycle after the last grant.
- FIFO:
  - Registered storage with Depth entries and pointer wrap-around modulo Depth.
  - No combinational path from op_data_i to store_op_o: a beat pushed in cycle N is visible on store_op_o no earlier than cycle N+1.
  - Full: op_ready_o = 0 even if a pop happens in the same cycle (no pop-through).
  - Push and pop in the same cycle while neither full nor empty: occupancy is unchanged.
  - Sustained throughput is 1 beat/cycle when the LSU grants every cycle.
- Output handshake:
  - store_op_valid_o = !fifo_empty.
  - While valid is high and not granted, store_op_o is held stable.
  - store_op_gnt_i while store_op_valid_o is low is ignored; no state change.
  - Beats leave in exactly the order they were accepted.
- Flush:
  - Synchronous; highest priority, taking effect at the next clock edge.
  - Empties the FIFO, clears in_rem and out_rem, and returns to IDLE from any state.
  - No done_o pulse for the aborted instruction.
  - A flush while in DONE still lets that cycle's done_o pulse appear, since it was already registered.
  - During the flush cycle insn_ready_o = 0 and op_ready_o = 0, so nothing is accepted.
  - A grant in the flush cycle is still a legal handshake; the popped beat counts as delivered.
- Excess beats: once in_rem == 0, op_ready_o stays 0 until the next instruction is accepted.
- Reset mid-operation: returns immediately to the reset state, with any buffered data discarded.

Test Plan:
- Basic transfer: insn ID 5, beat_cnt 8, beats 0x10..0x17 offered back-to-back, store_op_gnt_i tied high.
  - Eight beats leave in order.
  - First store_op_valid_o appears 1 cycle after the first op accept.
  - done_o pulses once with ID 5 in the cycle after 0x17 is granted.
- Backpressure: beat_cnt 8, gnt held low for 6 cycles.
  - op_ready_o drops after 4 accepts (Depth).
  - store_op_o holds 0x10 stably.
  - After gnt rises, all 8 beats drain in order and done_o pulses.
- Zero-length store: ID 2, beat_cnt 0.
  - done_o = 1 with ID 2 on the next cycle.
  - store_op_valid_o never rises; insn_ready_o is back to 1 the cycle after that.
- Flush mid-store: ID 3, beat_cnt 6; flush asserted after 3 grants.
  - No done_o for ID 3; FIFO empty the next cycle.
  - A following insn ID 4 with beat_cnt 2 completes normally with done ID 4.
- Excess and spurious signals:
  - After 4 of 4 beats accepted, op_valid_i held high: op_ready_o stays 0.
  - gnt pulsed while the FIFO is empty: no pop, no counter change.
- Back-to-back instructions: ID 1 (3 beats) then ID 6 (2 beats) offered continuously.
  - insn_ready_o is low from the accept of ID 1 through its DONE cycle.
  - Two done pulses occur, with IDs 1 then 6, and beat order is preserved.
